// File: rtl/mem_stage_v2.sv
// Memory stage: decodes each request to data memory, a memory-mapped IO slot or a fault,
// with sub-word lanes, a fixed-latency data-memory read and an IO req/ack handshake with timeout.
module mem_stage_v2 #(
    parameter int          DBITS        = 32,
    parameter int          DMEMADDRBITS = 13,
    parameter int          DMEMWORDBITS = 2,
    parameter int          DMEM_LATENCY = 1,
    parameter logic [31:0] IO_BASE      = 32'hF0000000,
    parameter int          IO_SLOTS     = 8,
    parameter int          IO_TIMEOUT   = 15
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    input  logic                                 req_write,
    input  logic [1:0]                           req_size,
    input  logic                                 req_signed,
    input  logic [DBITS-1:0]                     req_addr,
    input  logic [DBITS-1:0]                     req_wdata,
    input  logic [DBITS-1:0]                     req_pc,
    input  logic [1:0]                           req_regsel,
    output logic                                 stall,
    output logic                                 resp_valid,
    output logic [DBITS-1:0]                     load_data,
    output logic [DBITS-1:0]                     fwd_value,
    output logic                                 fault,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] dmem_addr,
    output logic [DBITS-1:0]                     dmem_wdata,
    output logic [3:0]                           dmem_be,
    output logic                                 dmem_we,
    output logic                                 dmem_re,
    input  logic [DBITS-1:0]                     dmem_rdata,
    output logic                                 io_req,
    output logic [IO_SLOTS-1:0]                  io_sel,
    output logic                                 io_we,
    output logic [3:0]                           io_be,
    output logic [DBITS-1:0]                     io_wdata,
    input  logic                                 io_ack,
    input  logic [DBITS-1:0]                     io_rdata,
    output logic [1:0]                           dbg_state_o
);
    // Handshake: the upstream holds req_* stable while stall=1; a request is
    // consumed in the cycle resp_valid=1 and a new one may be presented the next cycle.

    localparam int SLOT_BITS = (IO_SLOTS > 1) ? $clog2(IO_SLOTS) : 1;
    localparam int TO_W      = $clog2(IO_TIMEOUT + 1);
    localparam int LAT_W     = 3;
    localparam logic [DBITS-1:0] IO_SPAN = DBITS'(4 * IO_SLOTS);

    typedef enum logic [1:0] {S_IDLE, S_DMEM_WAIT, S_IO_WAIT, S_IO_DONE} state_t;

    state_t               state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 io_req_q, io_req_d;
    logic [IO_SLOTS-1:0]  io_sel_q, io_sel_d;
    logic                 io_we_q, io_we_d;
    logic [3:0]           io_be_q, io_be_d;
    logic [DBITS-1:0]     io_wdata_q, io_wdata_d;
    logic [DBITS-1:0]     io_rdata_q, io_rdata_d;
    logic                 io_fault_q, io_fault_d;

    logic [1:0]           off;
    logic [3:0]           lane_be;
    logic [DBITS-1:0]     lane_wdata;
    logic                 is_dmem, is_io, misaligned, dec_fault;
    logic [SLOT_BITS-1:0] slot;

    function automatic logic [DBITS-1:0] extend(input logic [DBITS-1:0] raw,
                                                input logic [1:0] o,
                                                input logic [1:0] size,
                                                input logic sgn);
        logic [DBITS-1:0] s;
        s = raw >> {o, 3'b000};
        case (size)
            2'b00:   extend = sgn ? {{24{s[7]}}, s[7:0]}   : {24'b0, s[7:0]};
            2'b01:   extend = sgn ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: extend = s;
        endcase
    endfunction

    always_comb begin
        off  = req_addr[1:0];
        slot = req_addr[2 +: SLOT_BITS];
        case (req_size)
            2'b00:   begin lane_be = 4'b0001 << off; lane_wdata = {4{req_wdata[7:0]}};  end
            2'b01:   begin lane_be = 4'b0011 << off; lane_wdata = {2{req_wdata[15:0]}}; end
            default: begin lane_be = 4'b1111;        lane_wdata = req_wdata;            end
        endcase
        is_dmem    = (req_addr >> DMEMADDRBITS) == '0;
        // Unsigned subtract wraps addresses below IO_BASE far above the window.
        is_io      = (req_addr - IO_BASE) < IO_SPAN;
        misaligned = (req_size == 2'b11) || (req_size == 2'b01 && off[0]) ||
                     (req_size == 2'b10 && off != 2'b00);
        dec_fault  = misaligned || !(is_dmem || is_io);
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        to_d       = to_q;
        io_req_d   = io_req_q;
        io_sel_d   = io_sel_q;
        io_we_d    = io_we_q;
        io_be_d    = io_be_q;
        io_wdata_d = io_wdata_q;
        io_rdata_d = io_rdata_q;
        io_fault_d = io_fault_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        fault      = 1'b0;
        load_data  = '0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = 4'b0000;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (dec_fault) begin
                        resp_valid = 1'b1;
                        fault      = 1'b1;
                    end else if (is_dmem) begin
                        dmem_addr = req_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                        dmem_be   = lane_be;
                        if (req_write) begin
                            dmem_we    = 1'b1;
                            dmem_wdata = lane_wdata;
                            resp_valid = 1'b1;
                        end else begin
                            dmem_re = 1'b1;
                            stall   = 1'b1;
                            lat_d   = LAT_W'(1);
                            state_d = S_DMEM_WAIT;
                        end
                    end else begin
                        stall            = 1'b1;
                        io_req_d         = 1'b1;
                        io_sel_d         = '0;
                        io_sel_d[slot]   = 1'b1;
                        io_we_d          = req_write;
                        io_be_d          = lane_be;
                        io_wdata_d       = lane_wdata;
                        io_fault_d       = 1'b0;
                        to_d             = '0;
                        state_d          = S_IO_WAIT;
                    end
                end
            end
            S_DMEM_WAIT: begin
                if (lat_q == LAT_W'(DMEM_LATENCY)) begin
                    resp_valid = 1'b1;
                    load_data  = extend(dmem_rdata, off, req_size, req_signed);
                    lat_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    stall = 1'b1;
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_IO_WAIT: begin
                stall = 1'b1;
                // An ack in the cycle the timeout would fire still wins.
                if (io_ack || to_q == TO_W'(IO_TIMEOUT - 1)) begin
                    io_req_d   = 1'b0;
                    io_sel_d   = '0;
                    io_we_d    = 1'b0;
                    io_be_d    = 4'b0000;
                    io_wdata_d = '0;
                    io_rdata_d = io_rdata;
                    io_fault_d = !io_ack;
                    to_d       = io_ack ? to_q : TO_W'(IO_TIMEOUT);
                    state_d    = S_IO_DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_IO_DONE: begin
                resp_valid = 1'b1;
                fault      = io_fault_q;
                if (!io_fault_q && !req_write)
                    load_data = extend(io_rdata_q, off, req_size, req_signed);
                to_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fwd_value = '0;
        if (resp_valid) begin
            case (req_regsel)
                2'b01:   fwd_value = load_data;
                2'b10:   fwd_value = req_pc;
                default: fwd_value = req_addr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            to_q       <= '0;
            io_req_q   <= 1'b0;
            io_sel_q   <= '0;
            io_we_q    <= 1'b0;
            io_be_q    <= 4'b0000;
            io_wdata_q <= '0;
            io_rdata_q <= '0;
            io_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            to_q       <= to_d;
            io_req_q   <= io_req_d;
            io_sel_q   <= io_sel_d;
            io_we_q    <= io_we_d;
            io_be_q    <= io_be_d;
            io_wdata_q <= io_wdata_d;
            io_rdata_q <= io_rdata_d;
            io_fault_q <= io_fault_d;
        end
    end

    assign io_req      = io_req_q;
    assign io_sel      = io_sel_q;
    assign io_we       = io_we_q;
    assign io_be       = io_be_q;
    assign io_wdata    = io_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage_v2.sv
// Directed bench for mem_stage_v2 with DMEM_LATENCY=2: a byte-enable data memory model,
// hand-driven IO acks and hand-computed expected values checked at the falling edge.
module tb_mem_stage_v2;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size, req_regsel;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        stall, resp_valid, fault;
    logic [31:0] load_data, fwd_value;
    logic [10:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_we, dmem_re;
    logic        io_req, io_we, io_ack;
    logic [7:0]  io_sel;
    logic [3:0]  io_be;
    logic [31:0] io_wdata, io_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_stage_v2 #(.DMEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .req_regsel(req_regsel),
        .stall(stall), .resp_valid(resp_valid), .load_data(load_data),
        .fwd_value(fwd_value), .fault(fault),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
        .io_req(io_req), .io_sel(io_sel), .io_we(io_we), .io_be(io_be),
        .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata),
        .dbg_state_o(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // data memory: byte-enable writes, read data valid two cycles after dmem_re
    logic [31:0] mem [0:2047];
    logic [31:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        if (dmem_we)
            for (int i = 0; i < 4; i++)
                if (dmem_be[i]) mem[dmem_addr][8*i +: 8] <= dmem_wdata[8*i +: 8];
        rd_p0 <= dmem_re ? mem[dmem_addr] : 32'h0;
        rd_p1 <= rd_p0;
    end
    assign dmem_rdata = rd_p1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs,
                         input logic [31:0] pc);
        req_valid = v; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d; req_regsel = rs; req_pc = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    endtask

    initial begin
        reset = 1'b0; io_ack = 1'b0; io_rdata = 32'h0;
        idle();
        repeat (2) nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_resp", {31'b0, resp_valid}, 32'd0);
        chk("rst_io_req", {31'b0, io_req}, 32'd0);
        chk("rst_io_sel", {24'b0, io_sel}, 32'd0);
        chk("rst_strobes", {30'b0, dmem_we, dmem_re}, 32'd0);
        chk("rst_fwd", fwd_value, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);

        // sw 0xDEADBEEF @0x100
        nxt(); drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 2'b00, 32'h0);
        @(negedge clk);
        chk("sw_we", {31'b0, dmem_we}, 32'd1);
        chk("sw_be", {28'b0, dmem_be}, 32'hF);
        chk("sw_addr", {21'b0, dmem_addr}, 32'h40);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_resp", {31'b0, resp_valid}, 32'd1);
        chk("sw_stall", {31'b0, stall}, 32'd0);
        chk("sw_fwd", fwd_value, 32'h100);

        // lb signed @0x103 -> 0xFFFFFFDE at cycle 2
        nxt(); drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 2'b01, 32'h0);
        @(negedge clk);
        chk("lb_c0_re", {31'b0, dmem_re}, 32'd1);
        chk("lb_c0_be", {28'b0, dmem_be}, 32'h8);
        chk("lb_c0_stall", {31'b0, stall}, 32'd1);
        chk("lb_c0_resp", {31'b0, resp_valid}, 32'd0);
        nxt(); @(negedge clk);
        chk("lb_c1_stall", {31'b0, stall}, 32'd1);
        chk("lb_c1_re", {31'b0, dmem_re}, 32'd0);
        chk("lb_c1_state", {30'b0, dbg_state}, 32'd1);
        nxt(); @(negedge clk);
        chk("lb_c2_resp", {31'b0, resp_valid}, 32'd1);
        chk("lb_c2_stall", {31'b0, stall}, 32'd0);
        chk("lb_c2_data", load_data, 32'hFFFFFFDE);
        chk("lb_c2_fwd", fwd_value, 32'hFFFFFFDE);

        // lhu @0x102 -> 0x0000DEAD
        nxt(); drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 2'b00, 32'h0);
        @(negedge clk);
        chk("lhu_c0_stall", {31'b0, stall}, 32'd1);
        nxt(); nxt(); @(negedge clk);
        chk("lhu_resp", {31'b0, resp_valid}, 32'd1);
        chk("lhu_data", load_data, 32'h0000DEAD);
        chk("lhu_fault", {31'b0, fault}, 32'd0);

        // lh @0x101 misaligned -> immediate fault
        nxt(); drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 2'b01, 32'h0);
        @(negedge clk);
        chk("lh_mis_fault", {31'b0, fault}, 32'd1);
        chk("lh_mis_resp", {31'b0, resp_valid}, 32'd1);
        chk("lh_mis_re", {31'b0, dmem_re}, 32'd0);
        chk("lh_mis_stall", {31'b0, stall}, 32'd0);
        chk("lh_mis_data", load_data, 32'd0);

        // sw 0x3FF @0xF0000004, ack in cycle 4
        nxt(); drive(1'b1, 1'b1, 2'b10, 1'b0, 32'hF0000004, 32'h3FF, 2'b00, 32'h0);
        @(negedge clk);
        chk("iosw_c0_stall", {31'b0, stall}, 32'd1);
        chk("iosw_c0_req", {31'b0, io_req}, 32'd0);
        nxt(); @(negedge clk);
        chk("iosw_c1_req", {31'b0, io_req}, 32'd1);
        chk("iosw_c1_sel", {24'b0, io_sel}, 32'h02);
        chk("iosw_c1_we", {31'b0, io_we}, 32'd1);
        chk("iosw_c1_be", {28'b0, io_be}, 32'hF);
        chk("iosw_c1_wdata", io_wdata, 32'h3FF);
        nxt(); nxt(); @(negedge clk);
        chk("iosw_c3_req", {31'b0, io_req}, 32'd1);
        chk("iosw_c3_stall", {31'b0, stall}, 32'd1);
        nxt(); io_ack = 1'b1; @(negedge clk);
        chk("iosw_c4_req", {31'b0, io_req}, 32'd1);
        chk("iosw_c4_resp", {31'b0, resp_valid}, 32'd0);
        nxt(); io_ack = 1'b0; @(negedge clk);
        chk("iosw_c5_req", {31'b0, io_req}, 32'd0);
        chk("iosw_c5_resp", {31'b0, resp_valid}, 32'd1);
        chk("iosw_c5_fault", {31'b0, fault}, 32'd0);
        chk("iosw_c5_stall", {31'b0, stall}, 32'd0);

        // lw @0xF0000000 without ack -> timeout after 15 IO_WAIT cycles
        nxt(); drive(1'b1, 1'b0, 2'b10, 1'b0, 32'hF0000000, 32'h0, 2'b01, 32'h0);
        nxt(); @(negedge clk);
        chk("to_c1_req", {31'b0, io_req}, 32'd1);
        chk("to_c1_sel", {24'b0, io_sel}, 32'h01);
        repeat (14) nxt();
        @(negedge clk);
        chk("to_c15_req", {31'b0, io_req}, 32'd1);
        chk("to_c15_resp", {31'b0, resp_valid}, 32'd0);
        nxt(); @(negedge clk);
        chk("to_c16_req", {31'b0, io_req}, 32'd0);
        chk("to_c16_resp", {31'b0, resp_valid}, 32'd1);
        chk("to_c16_fault", {31'b0, fault}, 32'd1);
        chk("to_c16_data", load_data, 32'd0);

        // late ack while idle is ignored
        nxt(); idle(); io_ack = 1'b1; @(negedge clk);
        chk("late_ack_resp", {31'b0, resp_valid}, 32'd0);
        nxt(); io_ack = 1'b0; @(negedge clk);
        chk("late_ack_state", {30'b0, dbg_state}, 32'd0);

        // unmapped lw with regsel=PC
        nxt(); drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0, 2'b10, 32'h44);
        @(negedge clk);
        chk("unm_fault", {31'b0, fault}, 32'd1);
        chk("unm_resp", {31'b0, resp_valid}, 32'd1);
        chk("unm_strobes", {30'b0, dmem_we, dmem_re}, 32'd0);
        chk("unm_fwd", fwd_value, 32'h44);

        // reserved size store
        nxt(); drive(1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 32'h1234, 2'b00, 32'h0);
        @(negedge clk);
        chk("rsv_fault", {31'b0, fault}, 32'd1);
        chk("rsv_we", {31'b0, dmem_we}, 32'd0);

        // lw @0xF000001C, ack in cycle 1 with data
        nxt(); drive(1'b1, 1'b0, 2'b10, 1'b0, 32'hF000001C, 32'h0, 2'b01, 32'h0);
        io_rdata = 32'h12345678;
        nxt(); io_ack = 1'b1; @(negedge clk);
        chk("iolw_sel", {24'b0, io_sel}, 32'h80);
        chk("iolw_we", {31'b0, io_we}, 32'd0);
        nxt(); io_ack = 1'b0; io_rdata = 32'h0; @(negedge clk);
        chk("iolw_resp", {31'b0, resp_valid}, 32'd1);
        chk("iolw_data", load_data, 32'h12345678);
        chk("iolw_fwd", fwd_value, 32'h12345678);

        // reset during IO_WAIT abandons the access
        nxt(); drive(1'b1, 1'b1, 2'b10, 1'b0, 32'hF0000008, 32'h55, 2'b00, 32'h0);
        nxt(); @(negedge clk);
        chk("rmid_c1_req", {31'b0, io_req}, 32'd1);
        nxt(); reset = 1'b0; idle();
        nxt(); reset = 1'b1; @(negedge clk);
        chk("rmid_req", {31'b0, io_req}, 32'd0);
        chk("rmid_stall", {31'b0, stall}, 32'd0);
        chk("rmid_resp", {31'b0, resp_valid}, 32'd0);
        chk("rmid_sel", {24'b0, io_sel}, 32'd0);

        // normal traffic after reset: sw, lbu, sb replication
        nxt(); drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344, 2'b00, 32'h0);
        @(negedge clk);
        chk("post_sw_resp", {31'b0, resp_valid}, 32'd1);
        chk("post_sw_we", {31'b0, dmem_we}, 32'd1);
        nxt(); drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h105, 32'h0, 2'b00, 32'h0);
        nxt(); nxt(); @(negedge clk);
        chk("post_lbu_resp", {31'b0, resp_valid}, 32'd1);
        chk("post_lbu_data", load_data, 32'h00000033);
        nxt(); drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h106, 32'h000000A5, 2'b00, 32'h0);
        @(negedge clk);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_be", {28'b0, dmem_be}, 32'h4);
        nxt(); idle(); @(negedge clk);
        chk("end_idle_resp", {31'b0, resp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
